// File: rtl/fir_sched_if.sv
// Sample, filter-side and output signals between fir_sched and its neighbours.
// master: sample source plus filter pair; slave: fir_sched.
interface fir_sched_if #(
   parameter int unsigned DW = 16
);
   logic          smp_valid;
   logic [DW-1:0] sin_raw;
   logic [DW-1:0] cos_raw;
   logic          flush;
   logic          fir_en;
   logic [DW-1:0] sin_fir_in;
   logic [DW-1:0] cos_fir_in;
   logic [DW-1:0] sin_fir_out;
   logic [DW-1:0] cos_fir_out;
   logic [DW-1:0] sin_out;
   logic [DW-1:0] cos_out;
   logic          out_valid;
   logic          settled;
   logic          overrun;

   modport master (
      output smp_valid, sin_raw, cos_raw, flush, sin_fir_out, cos_fir_out,
      input  fir_en, sin_fir_in, cos_fir_in, sin_out, cos_out, out_valid, settled, overrun
   );

   modport slave (
      input  smp_valid, sin_raw, cos_raw, flush, sin_fir_out, cos_fir_out,
      output fir_en, sin_fir_in, cos_fir_in, sin_out, cos_out, out_valid, settled, overrun
   );
endinterface

// File: rtl/fir_sched.sv
// Sample scheduler and warm-up controller for the sin/cos FIR pair.
// Optional output decimation is compiled in with `define FIR_SCHED_DECIM_EN.
module fir_sched #(
   parameter int unsigned DW      = 16,
   parameter int unsigned TAPS    = 32,
   parameter int unsigned LAT     = 1,
   parameter int unsigned MIN_GAP = 4,
   parameter int unsigned DECIM   = 4
) (
   input  logic       clk,
   input  logic       rst,
   fir_sched_if.slave bus
);
   localparam int unsigned FCW = $clog2(TAPS + 1);
   localparam int unsigned GCW = $clog2(MIN_GAP + 1);
   localparam int unsigned DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned PD  = LAT + 1;
`ifdef FIR_SCHED_DECIM_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [FCW-1:0] fill_q, fill_d, fill_inc;
   logic [GCW-1:0] gap_q, gap_d;
   logic [DCW-1:0] dec_q, dec_d, dec_cur;
   logic [PD-1:0]  pipe_q, pipe_d;
   logic           any_q, any_d;
   logic           ovr_q, ovr_d;
   logic           accept_c, eligible_c, tag_c, capture_c;
   logic           fir_en_q, out_valid_q, settled_q;
   logic [DW-1:0]  sin_in_q, cos_in_q, sin_out_q, cos_out_q;

   // Acceptance, fill/RUN sequencing, decimation phase and capture-tag pipe
   always_comb begin
      state_d    = state_q;
      fill_d     = fill_q;
      gap_d      = (gap_q < GCW'(MIN_GAP)) ? gap_q + GCW'(1) : gap_q;
      dec_d      = dec_q;
      dec_cur    = '0;
      any_d      = any_q;
      ovr_d      = ovr_q;
      pipe_d     = {pipe_q[PD-2:0], 1'b0};
      eligible_c = 1'b0;
      tag_c      = 1'b0;
      fill_inc   = (fill_q < FCW'(TAPS)) ? fill_q + FCW'(1) : fill_q;
      accept_c   = bus.smp_valid && (bus.flush || !any_q || (gap_q >= GCW'(MIN_GAP)));
      capture_c  = pipe_q[PD-1] && !bus.flush;

      if (accept_c) begin
         any_d = 1'b1;
         gap_d = GCW'(1);
      end

      if (bus.flush) begin
         // A sample arriving with flush becomes the first fill sample
         state_d = FILL;
         fill_d  = accept_c ? FCW'(1) : '0;
         any_d   = accept_c;
         ovr_d   = 1'b0;
         dec_d   = '0;
         pipe_d  = '0;
      end else begin
         if (bus.smp_valid && !accept_c) begin
            ovr_d = 1'b1;
         end
         if (accept_c) begin
            fill_d = fill_inc;
            case (state_q)
               IDLE: state_d = FILL;
               FILL: begin
                  if (fill_inc == FCW'(TAPS)) begin
                     state_d    = RUN;
                     eligible_c = 1'b1;
                  end
               end
               RUN:     eligible_c = 1'b1;
               default: state_d = IDLE;
            endcase
         end
         // Decimation phase restarts at zero on the sample that enters RUN
         if (eligible_c) begin
            dec_cur = (state_q == RUN) ? dec_q : '0;
            dec_d   = (dec_cur == DCW'(DECIM - 1)) ? '0 : dec_cur + DCW'(1);
            tag_c   = !DEC_EN || (dec_cur == '0);
         end
         pipe_d[0] = tag_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q      <= '0;
         gap_q       <= '0;
         dec_q       <= '0;
         pipe_q      <= '0;
         any_q       <= 1'b0;
         ovr_q       <= 1'b0;
         fir_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         settled_q   <= 1'b0;
         sin_in_q    <= '0;
         cos_in_q    <= '0;
         sin_out_q   <= '0;
         cos_out_q   <= '0;
      end else begin
         fill_q      <= fill_d;
         gap_q       <= gap_d;
         dec_q       <= dec_d;
         pipe_q      <= pipe_d;
         any_q       <= any_d;
         ovr_q       <= ovr_d;
         fir_en_q    <= accept_c;
         out_valid_q <= capture_c;
         settled_q   <= (state_d == RUN);
         if (accept_c) begin
            sin_in_q <= bus.sin_raw;
            cos_in_q <= bus.cos_raw;
         end
         if (capture_c) begin
            sin_out_q <= bus.sin_fir_out;
            cos_out_q <= bus.cos_fir_out;
         end
      end
   end

   assign bus.fir_en     = fir_en_q;
   assign bus.sin_fir_in = sin_in_q;
   assign bus.cos_fir_in = cos_in_q;
   assign bus.sin_out    = sin_out_q;
   assign bus.cos_out    = cos_out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.settled    = settled_q;
   assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_fir_sched.sv
// Bench for fir_sched: sample streams checked cycle by cycle against a
// transaction-level model (acceptance by spacing, fill count, output events).
module tb_fir_sched;
   localparam int unsigned DW      = 16;
   localparam int unsigned TAPS    = 32;
   localparam int unsigned LAT     = 1;
   localparam int unsigned MIN_GAP = 4;
   localparam int unsigned DECIM   = 4;
`ifdef FIR_SCHED_DECIM_EN
   localparam int DEC_RATIO = DECIM;
`else
   localparam int DEC_RATIO = 1;
`endif
   localparam logic [DW-1:0] KEY_S = 16'h5A5A;
   localparam logic [DW-1:0] KEY_C = 16'hC3C3;

   typedef struct packed {
      logic          fe;
      logic [DW-1:0] sfi;
      logic [DW-1:0] cfi;
      logic          ov;
      logic [DW-1:0] so;
      logic [DW-1:0] co;
      logic          st;
      logic          orun;
   } snap_t;

   typedef struct {
      int            at;
      logic [DW-1:0] s;
      logic [DW-1:0] c;
   } out_ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   fir_sched_if #(.DW(DW)) bus ();

   fir_sched #(
      .DW(DW), .TAPS(TAPS), .LAT(LAT), .MIN_GAP(MIN_GAP), .DECIM(DECIM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Filter stand-in (LAT=1): a keyed copy of its input one cycle after fir_en, noise otherwise
   logic [DW-1:0] fo_s = '0;
   logic [DW-1:0] fo_c = '0;
   assign bus.sin_fir_out = fo_s;
   assign bus.cos_fir_out = fo_c;
   always @(posedge clk) begin
      if (bus.fir_en) begin
         fo_s <= bus.sin_fir_in ^ KEY_S;
         fo_c <= bus.cos_fir_in ^ KEY_C;
      end else begin
         fo_s <= DW'($urandom);
         fo_c <= DW'($urandom);
      end
   end

   // Reference model state
   int      k = 0;
   int      m_last = 0;
   int      m_cnt = 0;
   bit      m_any = 1'b0;
   bit      m_ovr = 1'b0;
   out_ev_t pend[$];
   snap_t   exp_now = '0;

   function automatic snap_t snap();
      snap_t r;
      r = {bus.fir_en, bus.sin_fir_in, bus.cos_fir_in, bus.out_valid,
           bus.sin_out, bus.cos_out, bus.settled, bus.overrun};
      return r;
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      m_any = 1'b0;
      m_ovr = 1'b0;
      pend.delete();
      exp_now = '0;
   endtask

   // Drive one cycle, predict what the next cycle must show, advance to its negedge
   task automatic tick(input bit v, input logic [DW-1:0] s, input logic [DW-1:0] c, input bit fl);
      bit acc;
      bus.smp_valid = v;
      bus.sin_raw   = s;
      bus.cos_raw   = c;
      bus.flush     = fl;
      acc = v && (fl || !m_any || ((k - m_last) >= int'(MIN_GAP)));
      if (fl) begin
         m_cnt = 0;
         m_any = 1'b0;
         m_ovr = 1'b0;
         pend.delete();
      end else if (v && !acc) begin
         m_ovr = 1'b1;
      end
      exp_now.fe = acc;
      exp_now.ov = 1'b0;
      if (acc) begin
         m_any = 1'b1;
         m_last = k;
         m_cnt++;
         exp_now.sfi = s;
         exp_now.cfi = c;
         if (m_cnt >= int'(TAPS) && ((m_cnt - int'(TAPS)) % DEC_RATIO) == 0)
            pend.push_back('{at: k + 2 + int'(LAT), s: s ^ KEY_S, c: c ^ KEY_C});
      end
      if (pend.size() > 0 && pend[0].at == k + 1) begin
         exp_now.ov = 1'b1;
         exp_now.so = pend[0].s;
         exp_now.co = pend[0].c;
         void'(pend.pop_front());
      end
      exp_now.st   = (m_cnt >= int'(TAPS));
      exp_now.orun = m_ovr;
      @(posedge clk);
      @(negedge clk);
      k++;
      bus.smp_valid = 1'b0;
      bus.flush     = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (snap() !== exp_now) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", snap(), exp_now);
      end
      rst = 1'b0;
      k = 0;
   endtask

   task automatic test_fill();
      int n_fe = 0, n_ov = 0, first_ov = -1, first_st = -1, c32 = -1, n;
      bit v;
      for (int i = 0; i < 33 * int'(MIN_GAP) + 4; i++) begin
         v = (i % int'(MIN_GAP) == 0) && (i < 33 * int'(MIN_GAP));
         n = i / int'(MIN_GAP) + 1;
         if (v && n == 32) c32 = k;
         tick(v, DW'(n), DW'(-n), 1'b0);
         checks++;
         if (snap() !== exp_now) begin
            failures++;
            $display("FAIL fill cyc=%0d got=%h exp=%h", k, snap(), exp_now);
         end
         if (bus.fir_en) n_fe++;
         if (bus.out_valid) begin
            n_ov++;
            if (first_ov < 0) first_ov = k;
         end
         if (bus.settled && first_st < 0) first_st = k;
      end
      checks++;
      if (n_fe != 33) begin
         failures++;
         $display("FAIL fill_fe_count got=%0d exp=33", n_fe);
      end
      checks++;
      if (n_ov != ((DEC_RATIO == 1) ? 2 : 1)) begin
         failures++;
         $display("FAIL fill_ov_count got=%0d exp=%0d", n_ov, (DEC_RATIO == 1) ? 2 : 1);
      end
      checks++;
      if (first_ov != c32 + 3) begin
         failures++;
         $display("FAIL fill_first_ov got=%0d exp=%0d", first_ov, c32 + 3);
      end
      checks++;
      if (first_st != c32 + 1) begin
         failures++;
         $display("FAIL fill_settled_rise got=%0d exp=%0d", first_st, c32 + 1);
      end
   endtask

   task automatic test_overrun();
      int n_fe = 0;
      for (int i = 0; i < 10; i++) begin
         tick(i == 0 || i == 2 || i == 4, DW'($urandom), DW'($urandom), 1'b0);
         checks++;
         if (snap() !== exp_now) begin
            failures++;
            $display("FAIL overrun cyc=%0d got=%h exp=%h", k, snap(), exp_now);
         end
         if (bus.fir_en) n_fe++;
      end
      checks++;
      if (n_fe != 2) begin
         failures++;
         $display("FAIL overrun_fe_count got=%0d exp=2", n_fe);
      end
      checks++;
      if (bus.overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_sticky got=%b exp=1", bus.overrun);
      end
   endtask

   task automatic test_flush();
      int n_ov = 0, gap;
      for (int i = 0; i < 3; i++) begin
         tick(i == 0, DW'($urandom), DW'($urandom), i == 1);
         checks++;
         if (snap() !== exp_now) begin
            failures++;
            $display("FAIL flush_entry cyc=%0d got=%h exp=%h", k, snap(), exp_now);
         end
         if (bus.out_valid) n_ov++;
      end
      checks++;
      if (bus.settled !== 1'b0 || bus.overrun !== 1'b0) begin
         failures++;
         $display("FAIL flush_clear got=%b%b exp=00", bus.settled, bus.overrun);
      end
      for (int n = 0; n < 32; n++) begin
         gap = int'(MIN_GAP) + int'($urandom_range(0, 2));
         for (int j = 0; j < gap; j++) begin
            tick(j == 0, DW'($urandom), DW'($urandom), 1'b0);
            checks++;
            if (snap() !== exp_now) begin
               failures++;
               $display("FAIL flush_refill cyc=%0d got=%h exp=%h", k, snap(), exp_now);
            end
            if (bus.out_valid) n_ov++;
         end
      end
      checks++;
      if (n_ov != 1) begin
         failures++;
         $display("FAIL flush_ov_count got=%0d exp=1", n_ov);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 700; i++) begin
         tick($urandom_range(0, 2) == 0, DW'($urandom), DW'($urandom), $urandom_range(0, 299) == 0);
         checks++;
         if (snap() !== exp_now) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h exp=%h", k, snap(), exp_now);
         end
      end
   endtask

   task automatic test_reset_inflight();
      for (int i = 0; i <= 32 * int'(MIN_GAP); i++) begin
         tick(i % int'(MIN_GAP) == 0, DW'($urandom), DW'($urandom), i == 0);
         checks++;
         if (snap() !== exp_now) begin
            failures++;
            $display("FAIL inflight_setup cyc=%0d got=%h exp=%h", k, snap(), exp_now);
         end
      end
      #1 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (snap() !== exp_now) begin
         failures++;
         $display("FAIL reset_async got=%h exp=%h", snap(), exp_now);
      end
      @(negedge clk);
      k++;
      for (int i = 0; i < 14; i++) begin
         if (i == 2) rst = 1'b0;
         tick(i == 10, DW'($urandom), DW'($urandom), 1'b0);
         checks++;
         if (snap() !== exp_now) begin
            failures++;
            $display("FAIL reset_release cyc=%0d got=%h exp=%h", k, snap(), exp_now);
         end
      end
   endtask

   initial begin
      bus.smp_valid = 1'b0;
      bus.sin_raw   = '0;
      bus.cos_raw   = '0;
      bus.flush     = 1'b0;
      test_reset();
      test_fill();
      test_overrun();
      test_flush();
      test_random();
      test_reset_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
